// File: rtl/hssi_rst_seq_pkg.sv
// HSSI reset sequencer shared types and defaults.
package hssi_rst_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam int NUM_CH_DEF      = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/rst_seq_tmr.sv
// Ack-wait timer: counts while enabled, flags the last allowed cycle.
module rst_seq_tmr
  import hssi_rst_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt;

  assign expired = enable && (cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/hssi_rst_seq.sv
// HSSI channel reset sequencer: ordered assert, hold, ordered release.
// Optional ack timeout enabled by defining HSSI_RST_SEQ_TIMEOUT_EN.
module hssi_rst_seq
  import hssi_rst_seq_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rst_req,
  input  logic [NUM_CH-1:0] i_ch_ack,
  output logic [NUM_CH-1:0] o_ch_rst,
  output logic              o_ready,
  output logic              o_timeout_err,
  output logic [3:0]        o_err_ch
);

  if (NUM_CH < 1 || NUM_CH > 16 ||
      TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    $error("hssi_rst_seq: parameter out of range");
  end

  localparam logic [NUM_CH-1:0] ONE  = NUM_CH'(1);
  localparam logic [3:0]        LAST = 4'(NUM_CH - 1);

  state_t            state_q, state_n;
  logic [3:0]        idx_q, idx_n;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_n;
  logic [NUM_CH-1:0] sel, sel_nx;
  logic              ready_q, ready_n;
  logic              ack_hi;
  logic              expired;

  assign sel    = ONE << idx_q;
  assign sel_nx = ONE << (idx_q + 4'd1);
  assign ack_hi = |(i_ch_ack & sel);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ch_rst_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      ch_rst_q <= ch_rst_n;
      ready_q  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    ch_rst_n = ch_rst_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_rst_req) begin
          state_n  = S_ASSERT;
          idx_n    = '0;
          ch_rst_n = ch_rst_q | ONE;
        end
      end
      S_ASSERT: begin
        if (ack_hi || expired) begin
          if (idx_q == LAST) begin
            state_n = S_HOLD;
          end else begin
            idx_n    = idx_q + 4'd1;
            ch_rst_n = ch_rst_q | sel_nx;
          end
        end
      end
      S_HOLD: begin
        if (!i_rst_req) begin
          state_n  = S_RELEASE;
          idx_n    = '0;
          ch_rst_n = ch_rst_q & ~ONE;
        end
      end
      S_RELEASE: begin
        // A new request restarts assertion from channel 0 at once.
        if (i_rst_req) begin
          state_n  = S_ASSERT;
          idx_n    = '0;
          ch_rst_n = ch_rst_q | ONE;
        end else if (!ack_hi || expired) begin
          if (idx_q == LAST) begin
            state_n = S_IDLE;
          end else begin
            idx_n    = idx_q + 4'd1;
            ch_rst_n = ch_rst_q & ~sel_nx;
          end
        end
      end
    endcase
    ready_n = (state_n == S_IDLE) && (ch_rst_n == '0);
  end

  assign o_ch_rst = ch_rst_q;
  assign o_ready  = ready_q;

`ifdef HSSI_RST_SEQ_TIMEOUT_EN
  logic       tmr_clr, tmr_en, miss;
  logic       err_q;
  logic [3:0] err_ch_q;

  assign tmr_en  = (state_q == S_ASSERT) || (state_q == S_RELEASE);
  assign tmr_clr = (state_n != state_q) || (idx_n != idx_q);

  rst_seq_tmr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expired(expired)
  );

  assign miss = expired &&
    ((state_q == S_ASSERT && !ack_hi) ||
     (state_q == S_RELEASE && !i_rst_req && ack_hi));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q    <= 1'b0;
      err_ch_q <= '0;
    end else if (miss) begin
      err_q <= 1'b1;
      if (!err_q) err_ch_q <= idx_q;
    end
  end

  assign o_timeout_err = err_q;
  assign o_err_ch      = err_ch_q;
`else
  assign expired       = 1'b0;
  assign o_timeout_err = 1'b0;
  assign o_err_ch      = 4'd0;
`endif

endmodule

// File: doc/hssi_rst_seq.md
HSSI_RST_SEQ -- requirements
Module: hssi_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of channels sequenced, range 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: cycles allowed per ack wait, range 2..65535.
REQ-003 SHALL have port i_clk  input  1: clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port i_rst_req  input  1: level reset request for all channels.
REQ-006 SHALL have port i_ch_ack  input  NUM_CH: per-channel reset ack, bit k pairs with o_ch_rst[k].
REQ-007 SHALL have port o_ch_rst  output  NUM_CH: per-channel reset, registered.
REQ-008 SHALL have port o_ready  output  1: registered; 1 only in S_IDLE with all channels released.
REQ-009 SHALL have port o_timeout_err  output  1: sticky timeout flag.
REQ-010 SHALL have port o_err_ch  output  4: index of first channel that timed out.

Function
REQ-011 SHALL implement states S_IDLE, S_ASSERT, S_HOLD, S_RELEASE, with channel index idx.
REQ-012 S_IDLE: i_rst_req=1 -> S_ASSERT, idx=0, o_ch_rst[0] set on same edge.
REQ-013 S_ASSERT: i_ch_ack[idx]=1 sampled -> if idx=NUM_CH-1 go S_HOLD, else idx+1 and set o_ch_rst[idx+1] on same edge; one channel advanced per cycle minimum.
REQ-014 S_HOLD: all o_ch_rst=1; i_rst_req=0 -> S_RELEASE, idx=0, o_ch_rst[0] cleared on same edge.
REQ-015 S_RELEASE: i_ch_ack[idx]=0 sampled -> if idx=NUM_CH-1 go S_IDLE, else idx+1 and clear o_ch_rst[idx+1] on same edge.
REQ-016 Release order SHALL equal assert order (channel 0 first).
REQ-017 i_rst_req=1 during S_RELEASE SHALL go to S_ASSERT with idx=0 next edge; already-asserted channels with ack high advance one per cycle.
REQ-018 i_rst_req deasserting during S_ASSERT SHALL NOT abort; sequence completes through S_HOLD then releases.
REQ-019 o_ready SHALL be 1 in cycle after entering S_IDLE and 0 in cycle after leaving it.
REQ-020 Ack bits for channels other than idx SHALL be ignored.

Reset
REQ-021 i_rst SHALL force state S_IDLE, idx=0, o_ch_rst=0, o_ready=0, o_timeout_err=0, o_err_ch=0, timeout counter=0.
REQ-022 First cycle after i_rst deasserts with i_rst_req=0: o_ready SHALL go 1 on that edge.
REQ-023 i_rst during any state SHALL override all transitions in same cycle.

Configuration
REQ-024 Macro HSSI_RST_SEQ_TIMEOUT_EN defined: counter restarts at 0 on each idx/state change; reaching TIMEOUT_CYC-1 without required ack level treats ack as received, sets o_timeout_err, loads o_err_ch=idx if flag was 0.
REQ-025 Macro undefined: no counter, waits indefinitely, o_timeout_err and o_err_ch tied 0.
REQ-026 o_timeout_err and o_err_ch SHALL clear only on i_rst.

Structure
REQ-027 Package hssi_rst_seq_pkg SHALL hold state enum (2-bit) and default constants NUM_CH_DEF, TIMEOUT_CYC_DEF.
REQ-028 Timeout counter SHALL be sub-module rst_seq_tmr (inputs clear, enable; output expired), instantiated only under HSSI_RST_SEQ_TIMEOUT_EN.

Verification (NUM_CH=4, TIMEOUT_CYC=16)
REQ-029 Acks echo o_ch_rst after 3 cycles; pulse i_rst_req 20 cycles -> o_ch_rst goes 0001,0011,0111,1111 then releases 1110,1100,1000,0000 in order; o_ready returns 1.
REQ-030 Hold i_ch_ack[2]=0 with macro -> after 16 cycles in idx 2, o_timeout_err=1, o_err_ch=2, sequence reaches S_HOLD.
REQ-031 Same stimulus without macro -> o_ch_rst stays 0111 indefinitely, o_timeout_err=0.
REQ-032 Reassert i_rst_req when o_ch_rst=1100 during release -> state S_ASSERT, o_ch_rst returns to 1111, o_ready stays 0.
REQ-033 Assert i_rst in S_HOLD -> next edge o_ch_rst=0000, o_ready=0; following edge o_ready=1 with i_rst_req=0.
